// File: rtl/hash_update_scatter_4_if.sv
// Stream-in / four-lane-out bundle for the hash-update scatter block.
// The master drives the input stream and the bank ready signals; the slave is the scatter block.
interface hash_update_scatter_4_if #(
    parameter int DATA_W = 128,
    parameter int AW     = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_sel;
    logic [DATA_W-1:0]     in_data;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [DATA_W-1:0]     out_data0;
    logic [DATA_W-1:0]     out_data1;
    logic [DATA_W-1:0]     out_data2;
    logic [DATA_W-1:0]     out_data3;
    logic [4*(AW+1)-1:0]   lane_cnt;
    logic                  idle;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               lane_cnt, idle
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               lane_cnt, idle
    );
endinterface

// File: rtl/hash_update_scatter_4.sv
// Scatters one 128-bit hash-update stream to four bank lanes, each buffered by its own small FIFO
// so a stalled bank only blocks words addressed to it.

module hash_update_scatter_4_lane #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic              valid,
    output logic [DATA_W-1:0] head,
    output logic [AW:0]       cnt
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              pop;

    assign valid = (cnt != '0);
    assign pop   = valid && pop_ready;
    assign head  = mem[rptr];

    // Pointers are exactly AW bits, so they wrap at DEPTH without extra logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; contents are only observable while cnt != 0.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end
endmodule

module hash_update_scatter_4 #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hash_update_scatter_4_if.slave bus
);
    localparam int CW = AW + 1;

    logic [3:0]             push;
    logic [3:0]             valid;
    logic [3:0][CW-1:0]     cnt;
    logic [3:0][DATA_W-1:0] head;
    logic                   in_ready;

    // A full lane refuses input even when it pops in the same cycle.
    assign in_ready = (cnt[bus.in_sel] != CW'(DEPTH));

    always_comb begin
        push = '0;
        if (bus.in_valid && in_ready) push[bus.in_sel] = 1'b1;
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        hash_update_scatter_4_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .push_data (bus.in_data),
            .pop_ready (bus.out_ready[g]),
            .valid     (valid[g]),
            .head      (head[g]),
            .cnt       (cnt[g])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid;
    assign bus.out_data0 = head[0];
    assign bus.out_data1 = head[1];
    assign bus.out_data2 = head[2];
    assign bus.out_data3 = head[3];
    assign bus.lane_cnt  = cnt;
    assign bus.idle      = (cnt == '0) && !bus.in_valid;
endmodule

// File: tb/tb_hash_update_scatter_4.sv
// Randomised scoreboard bench for hash_update_scatter_4 against per-lane FIFO queue models.
module tb_hash_update_scatter_4;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;

    typedef logic [DATA_W-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hash_update_scatter_4_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    hash_update_scatter_4 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    word_t od [4];
    assign od[0] = bus.out_data0;
    assign od[1] = bus.out_data1;
    assign od[2] = bus.out_data2;
    assign od[3] = bus.out_data3;

    word_t exp_q [4][$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic word_t rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle of stimulus; the expected accept comes from the model occupancy only.
    task automatic drive(input logic v, input logic [1:0] s, input word_t d,
                         input logic [3:0] ordy, output logic acc);
        logic exp_rdy;
        @(negedge clk); #1;
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        exp_rdy = (exp_q[s].size() != DEPTH);
        chk("in_ready", bus.in_ready, exp_rdy);
        acc = v && exp_rdy && rst_n;
        if (acc) exp_q[s].push_back(d);
    endtask

    task automatic drain();
        logic acc;
        int   total;
        for (int k = 0; k < 20; k++) drive(1'b0, 2'd0, '0, 4'hF, acc);
        total = 0;
        for (int i = 0; i < 4; i++) total += exp_q[i].size();
        chk("drained", total, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 4'h0;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        #1;
        chk("rst_out_valid", bus.out_valid, 4'h0);
        chk("rst_lane_cnt", bus.lane_cnt, 12'h0);
        chk("rst_idle", bus.idle, 1'b1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // State monitor: late in the cycle, after all updates of the preceding edge have settled.
    initial forever begin
        @(posedge clk); #4;
        chk("idle", bus.idle,
            (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
             exp_q[2].size() == 0 && exp_q[3].size() == 0 && !bus.in_valid));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lane_cnt%0d", i), bus.lane_cnt[i*(AW+1) +: (AW+1)], exp_q[i].size());
            chk($sformatf("out_valid%0d", i), bus.out_valid[i], exp_q[i].size() != 0);
            if (exp_q[i].size() != 0) chk($sformatf("head%0d", i), od[i], exp_q[i][0]);
        end
    end

    // Pop monitor: consumes the model head on every lane handshake.
    initial forever begin
        @(negedge clk); #3;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid[i] && bus.out_ready[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("underflow%0d", i), 1'b1, 1'b0);
                end else begin
                    chk($sformatf("pop_data%0d", i), od[i], exp_q[i].pop_front());
                end
            end
        end
    end

    initial begin
        logic       acc;
        logic       v;
        logic       hold;
        logic [1:0] s;
        word_t      d;
        int         words;
        int         cyc;

        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'h0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", bus.out_valid, 4'h0);
        chk("reset_lane_cnt", bus.lane_cnt, 12'h0);
        chk("reset_idle", bus.idle, 1'b1);
        @(negedge clk); #1 rst_n = 1'b1;

        // one word per lane, consumed the cycle after it appears
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), word_t'(8'hA0 + i), 4'hF, acc);
        drain();

        // fill lane 2, full refusal, other lane ready, pop-without-push-through
        for (int i = 0; i < 4; i++) drive(1'b1, 2'd2, word_t'(8'h10 + i), 4'h0, acc);
        drive(1'b1, 2'd2, word_t'(8'h14), 4'h0, acc);
        drive(1'b0, 2'd1, '0, 4'h0, acc);
        drive(1'b1, 2'd2, word_t'(8'h14), 4'b0100, acc);
        drive(1'b1, 2'd2, word_t'(8'h14), 4'b0100, acc);
        drain();

        // lane 0 at cnt=2 with simultaneous push and pop
        drive(1'b1, 2'd0, rnd_word(), 4'h0, acc);
        drive(1'b1, 2'd0, rnd_word(), 4'h0, acc);
        for (int k = 0; k < 20; k++) drive(1'b1, 2'd0, rnd_word(), 4'b0001, acc);
        drain();

        // randomised traffic; a refused word is held stable until accepted
        words = 0;
        cyc   = 0;
        hold  = 1'b0;
        v     = 1'b0;
        s     = 2'd0;
        d     = '0;
        while (words < 10000 && cyc < 60000) begin
            if (!hold) begin
                v = ($urandom_range(3) != 0);
                s = 2'($urandom_range(3));
                d = rnd_word();
            end
            drive(v, s, d, 4'($urandom), acc);
            hold = v && !acc;
            if (acc) words++;
            cyc++;
        end
        chk("random_words", words, 10000);
        drain();

        // reset with lanes 1 and 3 partly full, then fresh traffic
        for (int i = 0; i < 2; i++) drive(1'b1, 2'd1, rnd_word(), 4'h0, acc);
        for (int i = 0; i < 3; i++) drive(1'b1, 2'd3, rnd_word(), 4'h0, acc);
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 2'($urandom_range(3)), rnd_word(), 4'hF, acc);
        drain();

        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
